// File: rtl/spd_ramp.sv
`default_nettype none
// ============================================================================
// spd_ramp : per-wheel duty slew limiter with reversal dwell and e-stop brake
// Rev 1.0  - initial release
// ============================================================================
module spd_ramp #(
  parameter int FAST_SIM   = 1,
  parameter int STEP       = 16,
  parameter int ESTOP_STEP = 128,
  parameter int DWELL      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        estop,
  input  logic        tgt_vld,
  input  logic [11:0] lft_tgt,
  input  logic [11:0] rght_tgt,
  output logic [11:0] lft_duty,
  output logic [11:0] rght_duty,
  output logic        at_tgt
);

  localparam logic [9:0]  PRE_MAX = (FAST_SIM != 0) ? 10'd15 : 10'd1023;
  localparam logic [12:0] STEP_C  = 13'(STEP);
  localparam logic [12:0] ESTOP_C = 13'(ESTOP_STEP);
  localparam logic [3:0]  DWELL_C = 4'(DWELL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  pre_q;
  logic        tick;
  logic        stop_req;
  logic        brake;
  logic        ramp;
  logic        tgt_load;
  logic        at_tgt_q, at_tgt_d;
  logic [1:0]  zero_nxt;
  logic [1:0]  match_nxt;
  logic [11:0] duty_cur [2];

  // Moves cur toward dst by at most stp; lands exactly on dst when within reach.
  function automatic logic [11:0] step_toward(input logic [11:0] cur,
                                              input logic [11:0] dst,
                                              input logic [12:0] stp);
    logic signed [12:0] diff;
    logic [12:0]        mag;
    diff = $signed({dst[11], dst}) - $signed({cur[11], cur});
    mag  = diff[12] ? 13'(-diff) : 13'(diff);
    if (mag <= stp)    return dst;
    else if (diff[12]) return cur - stp[11:0];
    else               return cur + stp[11:0];
  endfunction

  function automatic logic [11:0] sat(input logic [11:0] t);
    return (t == 12'h800) ? 12'h801 : t;
  endfunction

  assign tick     = (pre_q == PRE_MAX);
  assign stop_req = !go || estop;
  assign brake    = tick && ((state_q == STOP) || ((state_q == RUN) && stop_req));
  assign ramp     = tick && (state_q == RUN) && !stop_req;
  assign tgt_load = tgt_vld && (state_q != STOP) && (state_d != STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= tick ? '0 : pre_q + 10'd1;
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [11:0] duty_q, duty_d, tgt_q, tgt_raw;
    logic [3:0]  dw_q, dw_d;
    logic        rev_q, rev_d, dir_q, dir_d;
    logic        opp, dwelling;

    assign tgt_raw  = (ch == 0) ? lft_tgt : rght_tgt;
    assign opp      = (duty_q != '0) && (tgt_q != '0) && (duty_q[11] != tgt_q[11]);
    // Parked at zero after a reversal and still heading the same new direction.
    assign dwelling = rev_q && (duty_q == '0) && (tgt_q != '0) && (tgt_q[11] == dir_q);

    always_comb begin
      duty_d = duty_q;
      dw_d   = dw_q;
      rev_d  = rev_q;
      dir_d  = dir_q;
      if (brake) begin
        duty_d = step_toward(duty_q, 12'd0, ESTOP_C);
        rev_d  = 1'b0;
        dw_d   = '0;
      end else if (ramp) begin
        if (opp) begin
          duty_d = step_toward(duty_q, 12'd0, STEP_C);
          rev_d  = 1'b1;
          dir_d  = tgt_q[11];
          dw_d   = '0;
        end else if (dwelling && (dw_q != DWELL_C)) begin
          dw_d = dw_q + 4'd1;
        end else begin
          duty_d = step_toward(duty_q, tgt_q, STEP_C);
          rev_d  = 1'b0;
          dw_d   = '0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_q <= '0;
        tgt_q  <= '0;
        dw_q   <= '0;
        rev_q  <= 1'b0;
        dir_q  <= 1'b0;
      end else begin
        duty_q <= duty_d;
        dw_q   <= dw_d;
        rev_q  <= rev_d;
        dir_q  <= dir_d;
        if (tgt_load) tgt_q <= sat(tgt_raw);
      end
    end

    assign zero_nxt[ch]  = (duty_d == '0);
    assign match_nxt[ch] = (duty_d == tgt_q);
    assign duty_cur[ch]  = duty_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!stop_req) state_d = RUN;
      RUN:     if (stop_req) state_d = STOP;
      STOP:    if (&zero_nxt) state_d = stop_req ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    at_tgt_d = at_tgt_q;
    if (state_d != RUN) at_tgt_d = 1'b0;
    else if (ramp)      at_tgt_d = &match_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      at_tgt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      at_tgt_q <= at_tgt_d;
    end
  end

  assign lft_duty  = duty_cur[0];
  assign rght_duty = duty_cur[1];
  assign at_tgt    = at_tgt_q;

endmodule
`default_nettype wire

// File: tb/tb_spd_ramp.sv
`default_nettype none
// Testbench for spd_ramp: directed scenarios checked against an integer
// behavioural model every cycle, plus hand-computed literal expectations.
module tb_spd_ramp;

  localparam int STEP       = 16;
  localparam int ESTOP_STEP = 128;
  localparam int DWELL      = 4;
  localparam int PRE        = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        go       = 1'b0;
  logic        estop    = 1'b0;
  logic        tgt_vld  = 1'b0;
  logic [11:0] lft_tgt  = '0;
  logic [11:0] rght_tgt = '0;
  logic [11:0] lft_duty, rght_duty;
  logic        at_tgt;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_rev[10] = '{24, 8, 0, 0, 0, 0, 0, -16, -32, -40};

  spd_ramp #(
    .FAST_SIM  (1),
    .STEP      (STEP),
    .ESTOP_STEP(ESTOP_STEP),
    .DWELL     (DWELL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .estop    (estop),
    .tgt_vld  (tgt_vld),
    .lft_tgt  (lft_tgt),
    .rght_tgt (rght_tgt),
    .lft_duty (lft_duty),
    .rght_duty(rght_duty),
    .at_tgt   (at_tgt)
  );

  always #10 clk = ~clk;

  function automatic int sx(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode, m_pre, m_at;
  int m_duty[2];
  int m_tgt[2];
  int m_pend[2];   // direction (+1/-1) still owed a zero dwell, 0 if none
  int m_hold[2];   // ticks already spent parked at zero

  function automatic int toward(input int cur, input int dst, input int stp);
    if ((cur - dst <= stp) && (dst - cur <= stp)) return dst;
    return (dst > cur) ? cur + stp : cur - stp;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int msat(input int v);
    return (v == -2048) ? -2047 : v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pre = 0; m_at = 0;
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 0; m_tgt[c] = 0; m_pend[c] = 0; m_hold[c] = 0;
    end
  endtask

  task automatic model_run_channel(input int c);
    int d, t;
    d = m_duty[c];
    t = m_tgt[c];
    if (d * t < 0) begin
      m_duty[c] = toward(d, 0, STEP);
      m_pend[c] = sgn(t);
      m_hold[c] = 0;
    end else if (m_pend[c] != 0 && d == 0 && sgn(t) == m_pend[c] && m_hold[c] < DWELL) begin
      m_hold[c]++;
    end else begin
      m_duty[c] = toward(d, t, STEP);
      m_pend[c] = 0;
      m_hold[c] = 0;
    end
  endtask

  task automatic model_clk();
    bit stop_req, tick;
    int old_mode;
    stop_req = !go || estop;
    tick     = (m_pre == PRE - 1);
    m_pre    = tick ? 0 : m_pre + 1;
    old_mode = m_mode;
    if (tick) begin
      for (int c = 0; c < 2; c++) begin
        if (m_mode == M_STOP || (m_mode == M_RUN && stop_req)) begin
          m_duty[c] = toward(m_duty[c], 0, ESTOP_STEP);
          m_pend[c] = 0;
          m_hold[c] = 0;
        end else if (m_mode == M_RUN) begin
          model_run_channel(c);
        end
      end
    end
    if (m_mode == M_IDLE && !stop_req)     m_mode = M_RUN;
    else if (m_mode == M_RUN && stop_req)  m_mode = M_STOP;
    else if (m_mode == M_STOP && m_duty[0] == 0 && m_duty[1] == 0)
      m_mode = stop_req ? M_IDLE : M_RUN;
    if (m_mode != M_RUN) m_at = 0;
    else if (tick && old_mode == M_RUN)
      m_at = (m_duty[0] == m_tgt[0] && m_duty[1] == m_tgt[1]) ? 1 : 0;
    if (tgt_vld && old_mode != M_STOP && m_mode != M_STOP) begin
      m_tgt[0] = msat(sx(lft_tgt));
      m_tgt[1] = msat(sx(rght_tgt));
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_clk();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model lft_duty", sx(lft_duty), m_duty[0]);
      check("model rght_duty", sx(rght_duty), m_duty[1]);
      check("model at_tgt", int'(at_tgt), m_at);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_tick();
    int guard;
    guard = 0;
    @(negedge clk);
    while (m_pre != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL tick_wait: no tick within 40 clks, got none, expected one");
    end
  endtask

  task automatic send_tgt(input int l, input int r);
    lft_tgt  = 12'(l);
    rght_tgt = 12'(r);
    tgt_vld  = 1'b1;
    @(negedge clk);
    tgt_vld  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset lft_duty", sx(lft_duty), 0);
    check("reset rght_duty", sx(rght_duty), 0);
    check("reset at_tgt", int'(at_tgt), 0);
    rst_n = 1'b1;

    // Ramp up from rest at one STEP per tick
    next_tick();
    go = 1'b1;
    send_tgt(400, 0);
    for (int i = 1; i <= 24; i++) begin
      next_tick();
      check("ramp up lft", sx(lft_duty), 16 * i);
    end
    check("ramp up at_tgt before", int'(at_tgt), 0);
    next_tick();
    check("ramp up lft final", sx(lft_duty), 400);
    check("ramp up at_tgt", int'(at_tgt), 1);

    // Reversal with zero dwell on the right channel
    send_tgt(400, 40);
    repeat (3) next_tick();
    check("right settle 40", sx(rght_duty), 40);
    send_tgt(400, -40);
    for (int i = 0; i < 10; i++) begin
      next_tick();
      check("reversal seq", sx(rght_duty), exp_rev[i]);
      check("reversal lft steady", sx(lft_duty), 400);
    end

    // Target sign flips back during dwell: resume without waiting
    send_tgt(400, 40);
    repeat (5) next_tick();
    check("flipback parked", sx(rght_duty), 0);
    send_tgt(400, -40);
    next_tick();
    check("flipback resume", sx(rght_duty), -16);

    // Emergency stop from +1000 on both wheels
    send_tgt(1000, 1000);
    for (int i = 0; i < 120 && !at_tgt; i++) next_tick();
    check("settle 1000 at_tgt", int'(at_tgt), 1);
    check("settle 1000 lft", sx(lft_duty), 1000);
    check("settle 1000 rght", sx(rght_duty), 1000);
    estop = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      next_tick();
      check("estop lft", sx(lft_duty), (k < 8) ? 1000 - 128 * k : 0);
      check("estop rght", sx(rght_duty), (k < 8) ? 1000 - 128 * k : 0);
      check("estop at_tgt", int'(at_tgt), 0);
      if (k == 2) send_tgt(32, 32);
    end
    repeat (2) next_tick();
    check("idle after stop", sx(lft_duty), 0);

    // Restart: the target pulsed during STOP must not have been taken
    estop = 1'b0;
    repeat (3) next_tick();
    check("stop tgt ignored", sx(lft_duty), 48);
    estop = 1'b1;
    send_tgt(600, 600);
    next_tick();
    check("estop same clk lft", sx(lft_duty), 0);
    check("estop same clk rght", sx(rght_duty), 0);
    repeat (2) next_tick();
    check("estop same clk held", sx(lft_duty), 0);

    // Most-negative target saturates
    estop = 1'b0;
    send_tgt(-2048, 0);
    for (int i = 0; i < 200 && !at_tgt; i++) next_tick();
    check("sat lft", sx(lft_duty), -2047);
    check("sat at_tgt", int'(at_tgt), 1);

    // Asynchronous reset mid-ramp
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_tick();
    send_tgt(200, 200);
    repeat (13) next_tick();
    check("pre-reset lft", sx(lft_duty), 200);
    check("pre-reset at_tgt", int'(at_tgt), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset lft", sx(lft_duty), 0);
    check("async reset rght", sx(rght_duty), 0);
    check("async reset at_tgt", int'(at_tgt), 0);
    @(negedge clk);
    go    = 1'b0;
    rst_n = 1'b1;
    repeat (3) next_tick();
    check("idle after reset", sx(lft_duty), 0);
    go = 1'b1;
    send_tgt(64, -64);
    repeat (4) next_tick();
    check("restart lft", sx(lft_duty), 64);
    check("restart rght", sx(rght_duty), -64);
    check("restart at_tgt", int'(at_tgt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
